// File: rtl/ser_deframer.sv
`timescale 1ns/1ps
// ser_deframer
// Recovers framed payload words from a single-bit serial stream (MSB first).
// A frame is PAYLOAD_WORDS*DATA_W payload bits followed by SYNC_W sync bits.
// The block hunts for SYNC_WORD, confirms alignment over CONFIRM_N consecutive
// good syncs, then emits payload words. It drops lock after LOSS_N
// consecutive bad syncs.
//
// Ports:
//   clkin          serializer-domain clock, rising edge
//   reset_n        asynchronous active-low reset
//   sdata          serial data bit
//   sdata_en       qualifies sdata; only enabled cycles advance bit state
//   data_out       last recovered payload word (held between strobes)
//   data_valid     one-cycle strobe, data_out carries a new word
//   frame_start    asserted with data_valid on payload word 0
//   locked         frame alignment established
//   sync_err_count saturating count of bad syncs seen while locked
module ser_deframer #(
  parameter int unsigned       DATA_W        = 8,
  parameter int unsigned       PAYLOAD_WORDS = 3,
  parameter int unsigned       SYNC_W        = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD     = 8'hA5,
  parameter int unsigned       CONFIRM_N     = 2,
  parameter int unsigned       LOSS_N        = 3,
  parameter int unsigned       ERR_W         = 8
) (
  input  logic              clkin,
  input  logic              reset_n,
  input  logic              sdata,
  input  logic              sdata_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_start,
  output logic              locked,
  output logic [ERR_W-1:0]  sync_err_count
);

  localparam int unsigned PAYLOAD_BITS = PAYLOAD_WORDS * DATA_W;
  localparam int unsigned FRAME_LEN    = PAYLOAD_BITS + SYNC_W;
  localparam int unsigned CNT_W        = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned FILL_W       = (SYNC_W > 2) ? $clog2(SYNC_W) : 1;
  localparam int unsigned GOOD_W       = $clog2(CONFIRM_N + 1);
  localparam int unsigned MISS_W       = $clog2(LOSS_N + 1);

  localparam logic [CNT_W-1:0]  LAST_BIT       = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  FIRST_WORD_END = CNT_W'(DATA_W - 1);
  localparam logic [FILL_W-1:0] FILL_MAX       = FILL_W'(SYNC_W - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST      = GOOD_W'(CONFIRM_N - 1);
  localparam logic [MISS_W-1:0] MISS_LAST      = MISS_W'(LOSS_N - 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_CONFIRM,
    ST_LOCKED
  } state_t;

  state_t              state, state_d;
  logic [SYNC_W-1:0]   sync_sr, sync_sr_d;
  logic [DATA_W-1:0]   word_sr, word_sr_d;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
  logic [FILL_W-1:0]   hunt_fill, hunt_fill_d;
  logic [GOOD_W-1:0]   good_cnt, good_cnt_d;
  logic [MISS_W-1:0]   miss_cnt, miss_cnt_d;
  logic [ERR_W-1:0]    err_cnt_d;
  logic [DATA_W-1:0]   data_out_d;
  logic                data_valid_d;
  logic                frame_start_d;
  logic                locked_d;

  logic [SYNC_W-1:0]   sync_now;
  logic [DATA_W-1:0]   word_now;
  logic                sync_hit;
  logic                frame_end;
  logic                word_end;
  logic                hunt_armed;
  logic                drop_to_hunt;

  // Shift values including the bit presented this cycle, so decisions are
  // made on the enabled cycle that carries the last bit of a field.
  assign sync_now   = {sync_sr[SYNC_W-2:0], sdata};
  assign word_now   = {word_sr[DATA_W-2:0], sdata};
  assign sync_hit   = (sync_now == SYNC_WORD);
  assign frame_end  = (bit_cnt == LAST_BIT);
  assign hunt_armed = (hunt_fill == FILL_MAX);

  always_comb begin
    word_end = 1'b0;
    for (int unsigned w = 0; w < PAYLOAD_WORDS; w++) begin
      if (bit_cnt == CNT_W'((w + 1) * DATA_W - 1)) begin
        word_end = 1'b1;
      end
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_HUNT;
      sync_sr        <= '0;
      word_sr        <= '0;
      bit_cnt        <= '0;
      hunt_fill      <= '0;
      good_cnt       <= '0;
      miss_cnt       <= '0;
      sync_err_count <= '0;
      data_out       <= '0;
      data_valid     <= 1'b0;
      frame_start    <= 1'b0;
      locked         <= 1'b0;
    end else begin
      state          <= state_d;
      sync_sr        <= sync_sr_d;
      word_sr        <= word_sr_d;
      bit_cnt        <= bit_cnt_d;
      hunt_fill      <= hunt_fill_d;
      good_cnt       <= good_cnt_d;
      miss_cnt       <= miss_cnt_d;
      sync_err_count <= err_cnt_d;
      data_out       <= data_out_d;
      data_valid     <= data_valid_d;
      frame_start    <= frame_start_d;
      locked         <= locked_d;
    end
  end

  always_comb begin
    state_d       = state;
    sync_sr_d     = sync_sr;
    word_sr_d     = word_sr;
    bit_cnt_d     = bit_cnt;
    hunt_fill_d   = hunt_fill;
    good_cnt_d    = good_cnt;
    miss_cnt_d    = miss_cnt;
    err_cnt_d     = sync_err_count;
    data_out_d    = data_out;
    data_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    locked_d      = locked;
    drop_to_hunt  = 1'b0;

    if (sdata_en) begin
      sync_sr_d = sync_now;
      word_sr_d = word_now;
      bit_cnt_d = frame_end ? '0 : bit_cnt + 1'b1;

      unique case (state)
        ST_HUNT: begin
          // Bit counter stays at zero so that the cycle after a match is
          // payload bit 0.
          bit_cnt_d = '0;
          if (!hunt_armed) begin
            hunt_fill_d = hunt_fill + 1'b1;
          end
          if (hunt_armed && sync_hit) begin
            good_cnt_d = GOOD_W'(1);
            if (CONFIRM_N <= 1) begin
              state_d    = ST_LOCKED;
              locked_d   = 1'b1;
              miss_cnt_d = '0;
            end else begin
              state_d = ST_CONFIRM;
            end
          end
        end

        ST_CONFIRM: begin
          if (frame_end) begin
            if (sync_hit) begin
              good_cnt_d = good_cnt + 1'b1;
              if (good_cnt == GOOD_LAST) begin
                state_d    = ST_LOCKED;
                locked_d   = 1'b1;
                miss_cnt_d = '0;
              end
            end else begin
              drop_to_hunt = 1'b1;
            end
          end
        end

        ST_LOCKED: begin
          if (word_end) begin
            data_out_d    = word_now;
            data_valid_d  = 1'b1;
            frame_start_d = (bit_cnt == FIRST_WORD_END);
          end
          if (frame_end) begin
            if (sync_hit) begin
              miss_cnt_d = '0;
            end else begin
              if (sync_err_count != '1) begin
                err_cnt_d = sync_err_count + 1'b1;
              end
              if (miss_cnt == MISS_LAST) begin
                drop_to_hunt = 1'b1;
              end else begin
                miss_cnt_d = miss_cnt + 1'b1;
              end
            end
          end
        end

        default: begin
          drop_to_hunt = 1'b1;
        end
      endcase

      // Re-hunting starts from an empty sync window so stale bits from the
      // lost alignment cannot produce an immediate false match.
      if (drop_to_hunt) begin
        state_d     = ST_HUNT;
        locked_d    = 1'b0;
        sync_sr_d   = '0;
        hunt_fill_d = '0;
        bit_cnt_d   = '0;
        good_cnt_d  = '0;
        miss_cnt_d  = '0;
      end
    end
  end

endmodule

// File: tb/tb_ser_deframer.sv
`timescale 1ns/1ps
module tb_ser_deframer;

  localparam int FRAME = 32;

  logic       clkin = 1'b0;
  logic       reset_n = 1'b0;
  logic       sdata = 1'b0;
  logic       sdata_en = 1'b0;

  logic [7:0] d0, e0;
  logic       v0, fs0, l0;
  logic [7:0] d1;
  logic [1:0] e1;
  logic       v1, fs1, l1;

  int checks = 0;
  int failures = 0;

  always #5 clkin = ~clkin;

  ser_deframer #(.DATA_W(8), .PAYLOAD_WORDS(3), .SYNC_W(8), .SYNC_WORD(8'hA5),
                 .CONFIRM_N(2), .LOSS_N(3), .ERR_W(8)) u0 (
    .clkin(clkin), .reset_n(reset_n), .sdata(sdata), .sdata_en(sdata_en),
    .data_out(d0), .data_valid(v0), .frame_start(fs0), .locked(l0),
    .sync_err_count(e0));

  // Second instance: 2-bit error counter and quicker loss, for saturation.
  ser_deframer #(.DATA_W(8), .PAYLOAD_WORDS(3), .SYNC_W(8), .SYNC_WORD(8'hA5),
                 .CONFIRM_N(2), .LOSS_N(2), .ERR_W(2)) u1 (
    .clkin(clkin), .reset_n(reset_n), .sdata(sdata), .sdata_en(sdata_en),
    .data_out(d1), .data_valid(v1), .frame_start(fs1), .locked(l1),
    .sync_err_count(e1));

  // Behavioural model, one slot per instance.
  int         m_loss[2]   = '{3, 2};
  int         m_errmax[2] = '{255, 3};
  bit         m_aligned[2];
  bit         m_locked[2];
  int         m_good[2];
  int         m_miss[2];
  int         m_err[2];
  int         m_hunt_bits[2];
  logic [7:0] m_window[2];
  bit         m_frame[2][FRAME];
  int         m_pos[2];
  logic [7:0] m_do[2];
  bit         m_dv[2];
  bit         m_fs[2];

  logic [7:0] cap_w[$];
  logic       cap_fs[$];
  int         lock_at;
  int         seg_bits;
  logic       prev_l0;
  logic [7:0] exp_w[3] = '{8'h11, 8'h22, 8'h33};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_unalign(input int i);
    m_aligned[i]   = 1'b0;
    m_locked[i]    = 1'b0;
    m_hunt_bits[i] = 0;
    m_window[i]    = 8'h00;
    m_good[i]      = 0;
    m_miss[i]      = 0;
    m_pos[i]       = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      model_unalign(i);
      m_err[i] = 0;
      m_do[i]  = 8'h00;
      m_dv[i]  = 1'b0;
      m_fs[i]  = 1'b0;
    end
  endtask

  task automatic model_bit(input int i, input bit b);
    logic [7:0] w;
    logic [7:0] s;
    m_dv[i] = 1'b0;
    m_fs[i] = 1'b0;
    if (!m_aligned[i]) begin
      m_window[i] = {m_window[i][6:0], b};
      m_hunt_bits[i]++;
      if (m_hunt_bits[i] >= 8 && m_window[i] == 8'hA5) begin
        m_aligned[i] = 1'b1;
        m_good[i]    = 1;
        m_pos[i]     = 0;
      end
    end else begin
      m_frame[i][m_pos[i]] = b;
      m_pos[i]++;
      if (m_locked[i] && m_pos[i] <= 24 && (m_pos[i] % 8) == 0) begin
        for (int k = 0; k < 8; k++) w[7-k] = m_frame[i][m_pos[i]-8+k];
        m_do[i] = w;
        m_dv[i] = 1'b1;
        m_fs[i] = (m_pos[i] == 8);
      end
      if (m_pos[i] == FRAME) begin
        for (int k = 0; k < 8; k++) s[7-k] = m_frame[i][24+k];
        m_pos[i] = 0;
        if (!m_locked[i]) begin
          if (s == 8'hA5) begin
            m_good[i]++;
            if (m_good[i] == 2) begin
              m_locked[i] = 1'b1;
              m_miss[i]   = 0;
            end
          end else begin
            model_unalign(i);
          end
        end else if (s == 8'hA5) begin
          m_miss[i] = 0;
        end else begin
          m_miss[i]++;
          if (m_err[i] < m_errmax[i]) m_err[i]++;
          if (m_miss[i] == m_loss[i]) model_unalign(i);
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("u0_data_valid",  32'(v0),  32'(m_dv[0]));
    chk("u0_frame_start", 32'(fs0), 32'(m_fs[0]));
    chk("u0_data_out",    32'(d0),  32'(m_do[0]));
    chk("u0_locked",      32'(l0),  32'(m_locked[0]));
    chk("u0_sync_err",    32'(e0),  32'(m_err[0]));
    chk("u1_data_valid",  32'(v1),  32'(m_dv[1]));
    chk("u1_frame_start", 32'(fs1), 32'(m_fs[1]));
    chk("u1_data_out",    32'(d1),  32'(m_do[1]));
    chk("u1_locked",      32'(l1),  32'(m_locked[1]));
    chk("u1_sync_err",    32'(e1),  32'(m_err[1]));
  endtask

  // Present one input cycle; expects to be entered at a falling edge.
  task automatic step(input bit b, input bit en);
    sdata    = b;
    sdata_en = en;
    @(posedge clkin);
    if (en) begin
      model_bit(0, b);
      model_bit(1, b);
      seg_bits++;
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_dv[i] = 1'b0;
        m_fs[i] = 1'b0;
      end
    end
    @(negedge clkin);
    compare_all();
    if (v0) begin
      cap_w.push_back(d0);
      cap_fs.push_back(fs0);
    end
    if (l0 && !prev_l0 && lock_at < 0) lock_at = seg_bits;
    prev_l0 = l0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int k = 7; k >= 0; k--) begin
      repeat (gap) step(bit'($urandom_range(0, 1)), 1'b0);
      step(v[k], 1'b1);
    end
  endtask

  task automatic send_frame(input logic [7:0] sync, input int gap);
    send_byte(8'h11, gap);
    send_byte(8'h22, gap);
    send_byte(8'h33, gap);
    send_byte(sync, gap);
  endtask

  task automatic send_junk(input int gap);
    logic [4:0] j;
    j = 5'b01100;
    for (int k = 4; k >= 0; k--) begin
      repeat (gap) step(bit'($urandom_range(0, 1)), 1'b0);
      step(j[k], 1'b1);
    end
  endtask

  task automatic seg_begin();
    cap_w.delete();
    cap_fs.delete();
    lock_at  = -1;
    seg_bits = 0;
    prev_l0  = l0;
  endtask

  task automatic do_reset(input string tag);
    sdata_en = 1'b0;
    reset_n  = 1'b0;
    model_reset();
    @(negedge clkin);
    chk({tag, "_rst_data_out"},   32'(d0), 0);
    chk({tag, "_rst_data_valid"}, 32'(v0), 0);
    chk({tag, "_rst_locked"},     32'(l0), 0);
    chk({tag, "_rst_sync_err"},   32'(e0), 0);
    chk({tag, "_rst_u1_locked"},  32'(l1), 0);
    @(negedge clkin);
    reset_n = 1'b1;
    seg_begin();
  endtask

  task automatic check_words(input string tag, input int first);
    chk({tag, "_nwords"}, 32'(cap_w.size()), 32'(first + 3));
    for (int k = 0; k < 3; k++) begin
      if (first + k < cap_w.size()) begin
        chk($sformatf("%s_word%0d", tag, k), 32'(cap_w[first+k]), 32'(exp_w[k]));
        chk($sformatf("%s_fs%0d", tag, k), 32'(cap_fs[first+k]), (k == 0) ? 1 : 0);
      end
    end
  endtask

  initial begin
    // Clean lock
    do_reset("clean");
    send_junk(0);
    send_byte(8'hA5, 0);
    send_frame(8'hA5, 0);
    chk("clean_lock_bit", 32'(lock_at), 45);
    send_frame(8'hA5, 0);
    check_words("clean", 0);
    chk("clean_sync_err", 32'(e0), 0);

    // Enable gaps: one enabled cycle in three
    do_reset("gap");
    send_junk(2);
    send_byte(8'hA5, 2);
    send_frame(8'hA5, 2);
    chk("gap_lock_bit", 32'(lock_at), 45);
    send_frame(8'hA5, 2);
    check_words("gap", 0);

    // False sync: A5 seen in hunt, sync slot then carries 3C
    do_reset("false");
    send_junk(0);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h3C, 0);
    chk("false_locked_after_3c", 32'(l0), 0);
    send_frame(8'hA5, 0);
    send_frame(8'hA5, 0);
    chk("false_lock_bit", 32'(lock_at), 109);
    chk("false_no_early_words", 32'(cap_w.size()), 0);
    send_frame(8'hA5, 0);
    check_words("false", 0);

    // Loss of lock
    do_reset("loss");
    send_junk(0);
    send_byte(8'hA5, 0);
    send_frame(8'hA5, 0);
    send_frame(8'hA5, 0);
    send_frame(8'h5A, 0);
    send_frame(8'h5A, 0);
    chk("loss_locked_after_2miss", 32'(l0), 1);
    send_frame(8'hA5, 0);
    send_frame(8'h5A, 0);
    send_frame(8'h5A, 0);
    chk("loss_locked_after_good_2miss", 32'(l0), 1);
    send_frame(8'h5A, 0);
    chk("loss_locked_after_3miss", 32'(l0), 0);
    chk("loss_sync_err", 32'(e0), 5);
    send_frame(8'hA5, 0);
    chk("loss_nwords", 32'(cap_w.size()), 21);

    // Saturation on the 2-bit counter
    do_reset("sat");
    send_junk(0);
    send_byte(8'hA5, 0);
    send_frame(8'hA5, 0);
    for (int r = 0; r < 3; r++) begin
      send_frame(8'h5A, 0);
      send_frame(8'h5A, 0);
      if (r == 0) begin
        chk("sat_u1_lost", 32'(l1), 0);
        chk("sat_u1_err_round0", 32'(e1), 2);
      end
      send_frame(8'hA5, 0);
      send_frame(8'hA5, 0);
    end
    chk("sat_u1_err", 32'(e1), 3);
    chk("sat_u1_relocked", 32'(l1), 1);
    chk("sat_u0_err", 32'(e0), 6);
    chk("sat_u0_locked", 32'(l0), 1);

    // Reset mid-frame during payload word 1
    do_reset("mid");
    send_junk(0);
    send_byte(8'hA5, 0);
    send_frame(8'hA5, 0);
    send_byte(8'h11, 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("mid_pre_data_out", 32'(d0), 32'h11);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_async_data_out", 32'(d0), 0);
    chk("mid_async_locked", 32'(l0), 0);
    chk("mid_async_valid", 32'(v0), 0);
    chk("mid_async_fs", 32'(fs0), 0);
    chk("mid_async_err", 32'(e0), 0);
    model_reset();
    sdata_en = 1'b0;
    @(negedge clkin);
    @(negedge clkin);
    reset_n = 1'b1;
    seg_begin();
    send_junk(0);
    send_byte(8'hA5, 0);
    send_frame(8'hA5, 0);
    chk("mid_relock_bit", 32'(lock_at), 45);
    send_frame(8'hA5, 0);
    check_words("mid", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
